vga_plot_arbiter: RTL and testbench
===================================

Name: vga_plot_arbiter

Overview:
Shares the single plot port of the 160x120 VGA adapter between two pixel requesters: user cursor/load writes and the simulation redraw engine. Also owns a built-in full-screen clear sweep. It sits between control/simulation and vga_adapter, so reset-clear, user loads and generation redraws never collide on x/y/colour/plot. Output is one pixel per clock at most.

Parameters:
X_MAX, 160, screen width in pixels; valid x is 0..X_MAX-1
Y_MAX, 120, screen height in pixels; valid y is 0..Y_MAX-1
COLOUR_W, 3, colour width
CLEAR_COLOUR, 3'b000, colour written by the clear sweep

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
clear_start  in  1  single-cycle pulse; requests a full-screen clear
clear_busy  out  1  high while the clear sweep is active
usr_req  in  1  user pixel valid
usr_x  in  8  user x
usr_y  in  8  user y
usr_colour  in  COLOUR_W  user colour
usr_ack  out  1  combinational ready; transfer when usr_req&usr_ack at posedge
sim_req  in  1  simulation pixel valid
sim_x  in  8  simulation x
sim_y  in  8  simulation y
sim_colour  in  COLOUR_W  simulation colour
sim_ack  out  1  combinational ready; transfer when sim_req&sim_ack at posedge
vga_x  out  8  to vga_adapter.x
vga_y  out  8  to vga_adapter.y
vga_colour  out  COLOUR_W  to vga_adapter.colour
vga_plot  out  1  to vga_adapter.plot
oob_drop  out  1  one-cycle pulse: the last transfer was out of range and was discarded

Behaviour:
- Reset (sync, high):
  - next cycle state=IDLE; vga_x=vga_y=0, vga_colour=0, vga_plot=0; clear_busy=0; oob_drop=0; last_grant=SIM.
  - usr_ack=sim_ack=0 while reset is high.
  - Reset mid-clear aborts the sweep; it does not resume after release.
- States: IDLE (arbitrating) and CLEAR (sweeping).
- IDLE arbitration:
  - One requester high: it gets ack in the same cycle.
  - Both high: round-robin; grant the one not equal to last_grant. last_grant updates on each transfer.
  - Only one ack is high per cycle.
- clear_start in IDLE:
  - Forces both acks low that cycle.
  - Next cycle: CLEAR, sweep counters x=0, y=0, clear_busy=1.
  - clear_start while in CLEAR is ignored.
- CLEAR:
  - Both acks low every cycle.
  - Each cycle registers (x, y, CLEAR_COLOUR) with vga_plot=1.
  - x increments; at X_MAX-1 it wraps to 0 and y increments.
  - After (X_MAX-1, Y_MAX-1) is issued, return to IDLE.
  - clear_busy is high for exactly X_MAX*Y_MAX = 19200 cycles.
  - Arbitration resumes the cycle clear_busy falls.
- Latency: transfer at edge N gives vga_x/vga_y/vga_colour/vga_plot=1 during cycle N+1. Cycle with no transfer and no sweep gives vga_plot=0; vga_x/vga_y/vga_colour hold their last value.
- Back-to-back: a requester holding req with new data each cycle sustains 1 pixel/clock (alone) or 1 per 2 clocks (contended).
- Out of range (x>=X_MAX or y>=Y_MAX):
  - The request is still acked (consumed).
  - Next cycle vga_plot=0 and oob_drop=1; vga_* are not updated.
- Coordinates are compared unsigned and full 8-bit; no truncation.

Decomposition:
- Shared package holds:
  - X_MAX and Y_MAX constants.
  - Colour constants BLACK=3'b000, WHITE=3'b111.
  - State encoding IDLE=1'b0, CLEAR=1'b1.
  - Requester ids USR=1'b0, SIM=1'b1.
- One sub-module, clear_sweeper:
  - Holds the x/y raster counter with start/busy/done.
  - Emits the current coordinate.
- The arbiter owns the FSM, the round-robin and the output registers.

Test Plan:
- Reset then idle, no requests -> vga_plot=0, vga_x=vga_y=0, clear_busy=0, both acks 0.
- usr_req=1 alone with (5,7,3'b111) -> usr_ack=1 in the same cycle; next cycle vga_plot=1, vga_x=5, vga_y=7, vga_colour=7; sim_ack=0 throughout.
- usr_req and sim_req held high for 6 cycles with distinct data -> acks USR,SIM,USR,SIM,USR,SIM; vga_plot high 6 consecutive cycles carrying the matching data.
- clear_start pulse with usr_req held (10,10,7) -> clear_busy high 19200 cycles, plots (0,0),(1,0)..(159,0),(0,1)..(159,119) all colour 0, usr_ack=0 throughout; usr_ack=1 on the first cycle clear_busy=0, then (10,10,7) is plotted.
- sim_req with (160,3,7), then (3,120,7) -> each acked; following cycles vga_plot=0 and oob_drop=1; vga_x/vga_y unchanged.
- reset asserted at sweep cycle 100 -> next cycle clear_busy=0, vga_plot=0; after release, no further clear plots and arbitration works normally.

Source files
------------

// File: rtl/vga_plot_arbiter_pkg.sv
// Shared constants, state encoding and requester ids for the VGA plot arbiter.
// The arbiter and the clear sweeper both import this package.
package vga_plot_arbiter_pkg;

  localparam int X_MAX   = 160;
  localparam int Y_MAX   = 120;
  localparam int COORD_W = 8;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    USR = 1'b0,
    SIM = 1'b1
  } req_id_e;

  // Full 8-bit unsigned compare; large coordinates such as 200 must not wrap into range.
  function automatic logic coord_in_range(input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y,
                                          input int x_max,
                                          input int y_max);
    return (int'({24'd0, x}) < x_max) && (int'({24'd0, y}) < y_max);
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_clear_sweeper.sv
// Raster counter for the full-screen clear: walks x fastest, then y.
// Reports each coordinate while busy and flags the final one with done.
module clear_sweeper #(
  parameter int X_MAX = vga_plot_arbiter_pkg::X_MAX,
  parameter int Y_MAX = vga_plot_arbiter_pkg::Y_MAX
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] x,
  output logic [7:0] y
);

  logic       busy_q, busy_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic       last_x, last_y;

  always_comb begin
    last_x = (x_q == 8'(X_MAX - 1));
    last_y = (y_q == 8'(Y_MAX - 1));
    done   = busy_q && last_x && last_y;

    busy_d = busy_q;
    x_d    = x_q;
    y_d    = y_q;
    if (start && !busy_q) begin
      busy_d = 1'b1;
      x_d    = '0;
      y_d    = '0;
    end else if (busy_q) begin
      if (last_x) begin
        x_d = '0;
        if (last_y) begin
          busy_d = 1'b0;
          y_d    = '0;
        end else begin
          y_d = y_q + 8'd1;
        end
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      busy_q <= busy_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the vga_adapter plot port between user writes and the simulation redraw,
// with a built-in full-screen clear sweep that has priority over both.
module vga_plot_arbiter #(
  parameter int                  X_MAX        = vga_plot_arbiter_pkg::X_MAX,
  parameter int                  Y_MAX        = vga_plot_arbiter_pkg::Y_MAX,
  parameter int                  COLOUR_W     = 3,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear_start,
  output logic                clear_busy,
  input  logic                usr_req,
  input  logic [7:0]          usr_x,
  input  logic [7:0]          usr_y,
  input  logic [COLOUR_W-1:0] usr_colour,
  output logic                usr_ack,
  input  logic                sim_req,
  input  logic [7:0]          sim_x,
  input  logic [7:0]          sim_y,
  input  logic [COLOUR_W-1:0] sim_colour,
  output logic                sim_ack,
  output logic [7:0]          vga_x,
  output logic [7:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                oob_drop
);
  import vga_plot_arbiter_pkg::*;

  // Handshake: each requester holds req with stable data; ack is combinational and a
  // pixel transfers at the posedge where req && ack; ack may drop without a transfer.

  state_e              state_q, state_d;
  req_id_e             last_grant_q, last_grant_d;
  logic [7:0]          x_q, x_d, y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;
  logic                oob_q, oob_d;

  logic                arb_open;
  logic                usr_grant, sim_grant;
  logic [7:0]          sel_x, sel_y;
  logic [COLOUR_W-1:0] sel_colour;
  logic                sweep_start, sweep_done;
  logic [7:0]          sweep_x, sweep_y;

  clear_sweeper #(
    .X_MAX(X_MAX),
    .Y_MAX(Y_MAX)
  ) u_sweeper (
    .clock (clock),
    .reset (reset),
    .start (sweep_start),
    .done  (sweep_done),
    .x     (sweep_x),
    .y     (sweep_y)
  );

  always_comb begin
    arb_open    = !reset && (state_q == IDLE) && !clear_start;
    sweep_start = (state_q == IDLE) && clear_start;
    // Contention goes to whoever did not win the previous transfer.
    usr_grant   = arb_open && usr_req && (!sim_req || last_grant_q == SIM);
    sim_grant   = arb_open && sim_req && (!usr_req || last_grant_q == USR);
    sel_x       = usr_grant ? usr_x      : sim_x;
    sel_y       = usr_grant ? usr_y      : sim_y;
    sel_colour  = usr_grant ? usr_colour : sim_colour;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    oob_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
        end else if (usr_grant || sim_grant) begin
          last_grant_d = usr_grant ? USR : SIM;
          if (coord_in_range(sel_x, sel_y, X_MAX, Y_MAX)) begin
            x_d      = sel_x;
            y_d      = sel_y;
            colour_d = sel_colour;
            plot_d   = 1'b1;
          end else begin
            oob_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        x_d      = sweep_x;
        y_d      = sweep_y;
        colour_d = CLEAR_COLOUR;
        plot_d   = 1'b1;
        if (sweep_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= SIM;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      oob_q        <= oob_d;
    end
  end

  assign clear_busy = (state_q == CLEAR);
  assign usr_ack    = usr_grant;
  assign sim_ack    = sim_grant;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;
  assign oob_drop   = oob_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: expected output pixels are queued when a
// transfer or sweep step is driven and checked one cycle later by a monitor.
module tb_vga_plot_arbiter;

  logic       clock = 1'b0;
  logic       reset, clear_start, clear_busy;
  logic       usr_req, usr_ack, sim_req, sim_ack;
  logic [7:0] usr_x, usr_y, sim_x, sim_y;
  logic [2:0] usr_colour, sim_colour;
  logic [7:0] vga_x, vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, oob_drop;

  int tests_run    = 0;
  int tests_failed = 0;

  // Entry layout: {plot, oob, x, y, colour}
  logic [20:0] exp_q[$];
  logic [20:0] mon_e;
  bit          mon_en = 1'b0;

  // Reference model state
  bit         m_clr  = 1'b0;
  logic [7:0] m_cx   = '0;
  logic [7:0] m_cy   = '0;
  logic [7:0] held_x = '0;
  logic [7:0] held_y = '0;
  logic [2:0] held_c = '0;

  always #5 clock = ~clock;

  vga_plot_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .usr_req    (usr_req),
    .usr_x      (usr_x),
    .usr_y      (usr_y),
    .usr_colour (usr_colour),
    .usr_ack    (usr_ack),
    .sim_req    (sim_req),
    .sim_x      (sim_x),
    .sim_y      (sim_y),
    .sim_colour (sim_colour),
    .sim_ack    (sim_ack),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .oob_drop   (oob_drop)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pixel(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    if (x >= 8'd160 || y >= 8'd120) begin
      exp_q.push_back({1'b0, 1'b1, held_x, held_y, held_c});
    end else begin
      exp_q.push_back({1'b1, 1'b0, x, y, c});
      held_x = x;
      held_y = y;
      held_c = c;
    end
  endtask

  // Drive one cycle of inputs, check the combinational acks and clear_busy, update the model.
  task automatic step(input logic rst, input logic cs,
                      input logic ur, input logic [7:0] ux, input logic [7:0] uy, input logic [2:0] uc,
                      input logic sr, input logic [7:0] sx, input logic [7:0] sy, input logic [2:0] sc,
                      input logic eu, input logic es);
    @(posedge clock);
    #1;
    reset       = rst;
    clear_start = cs;
    usr_req     = ur;
    usr_x       = ux;
    usr_y       = uy;
    usr_colour  = uc;
    sim_req     = sr;
    sim_x       = sx;
    sim_y       = sy;
    sim_colour  = sc;
    @(negedge clock);
    chk(32'(usr_ack), 32'(eu), "usr_ack");
    chk(32'(sim_ack), 32'(es), "sim_ack");
    chk(32'(clear_busy), 32'(m_clr), "clear_busy");
    if (rst) begin
      m_clr  = 1'b0;
      held_x = '0;
      held_y = '0;
      held_c = '0;
    end else if (m_clr) begin
      exp_q.push_back({2'b10, m_cx, m_cy, 3'b000});
      held_x = m_cx;
      held_y = m_cy;
      held_c = 3'b000;
      if (m_cx == 8'd159) begin
        m_cx = '0;
        if (m_cy == 8'd119) m_clr = 1'b0;
        else                m_cy = m_cy + 8'd1;
      end else begin
        m_cx = m_cx + 8'd1;
      end
    end else if (cs) begin
      m_clr = 1'b1;
      m_cx  = '0;
      m_cy  = '0;
    end else if (eu) begin
      push_pixel(ux, uy, uc);
    end else if (es) begin
      push_pixel(sx, sy, sc);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 8'd0, 8'd0, 3'd0, 0, 8'd0, 8'd0, 3'd0, 0, 0);
  endtask

  // Monitor: one cycle after each queued expectation the registered outputs must match it.
  always @(posedge clock) begin
    #3;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk(32'({vga_plot, oob_drop, vga_x, vga_y, vga_colour}), 32'(mon_e), "pixel");
      end else begin
        chk(32'({vga_plot, oob_drop}), 32'd0, "no_plot");
      end
    end
  end

  initial begin
    logic [7:0] dx, dy;
    reset = 1'b1; clear_start = 1'b0;
    usr_req = 1'b0; usr_x = '0; usr_y = '0; usr_colour = '0;
    sim_req = 1'b0; sim_x = '0; sim_y = '0; sim_colour = '0;

    // Reset with requests pending: acks must stay low
    step(1, 0, 1, 8'd1, 8'd1, 3'd1, 1, 8'd2, 8'd2, 3'd2, 0, 0);
    step(1, 0, 0, 8'd0, 8'd0, 3'd0, 0, 8'd0, 8'd0, 3'd0, 0, 0);
    mon_en = 1'b1;

    // Idle after reset
    idle();
    chk(32'(vga_x), 32'd0, "rst_vga_x");
    chk(32'(vga_y), 32'd0, "rst_vga_y");
    chk(32'(vga_colour), 32'd0, "rst_vga_colour");
    chk(32'(vga_plot), 32'd0, "rst_vga_plot");
    chk(32'(oob_drop), 32'd0, "rst_oob_drop");

    // Single user write
    step(0, 0, 1, 8'd5, 8'd7, 3'b111, 0, 8'd0, 8'd0, 3'd0, 1, 0);
    idle();

    // Reset so last_grant is SIM, then contention alternates starting with USR
    step(1, 0, 0, 8'd0, 8'd0, 3'd0, 0, 8'd0, 8'd0, 3'd0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 8'(i + 1), 8'(i + 20), 3'(i), 1, 8'(i + 40), 8'(i + 60), 3'(~i),
           (i % 2) == 0, (i % 2) == 1);
    end
    idle();

    // Boundary in-range pixel, then out-of-range drops
    step(0, 0, 1, 8'd159, 8'd119, 3'd5, 0, 8'd0, 8'd0, 3'd0, 1, 0);
    step(0, 0, 0, 8'd0, 8'd0, 3'd0, 1, 8'd160, 8'd3, 3'd7, 0, 1);
    step(0, 0, 0, 8'd0, 8'd0, 3'd0, 1, 8'd3, 8'd120, 3'd7, 0, 1);
    step(0, 0, 0, 8'd0, 8'd0, 3'd0, 1, 8'd200, 8'd255, 3'd7, 0, 1);
    idle();
    chk(32'(vga_x), 32'd159, "oob_hold_x");
    chk(32'(vga_y), 32'd119, "oob_hold_y");

    // Full clear with a user request held throughout; a second clear_start mid-sweep is ignored
    step(0, 1, 1, 8'd10, 8'd10, 3'd7, 0, 8'd0, 8'd0, 3'd0, 0, 0);
    for (int i = 0; i < 19200; i++) begin
      step(0, i == 50, 1, 8'd10, 8'd10, 3'd7, (i % 3) == 0, 8'd1, 8'd1, 3'd1, 0, 0);
    end
    step(0, 0, 1, 8'd10, 8'd10, 3'd7, 0, 8'd0, 8'd0, 3'd0, 1, 0);
    idle();

    // Reset at sweep cycle 100 aborts the clear for good
    step(0, 1, 0, 8'd0, 8'd0, 3'd0, 0, 8'd0, 8'd0, 3'd0, 0, 0);
    for (int i = 0; i < 100; i++) idle();
    step(1, 0, 0, 8'd0, 8'd0, 3'd0, 0, 8'd0, 8'd0, 3'd0, 0, 0);
    for (int i = 0; i < 4; i++) idle();
    chk(32'(vga_plot), 32'd0, "abort_plot");
    dx = 8'd20;
    dy = 8'd30;
    step(0, 0, 1, dx, dy, 3'd2, 1, 8'd40, 8'd50, 3'd4, 1, 0);
    step(0, 0, 1, dx, dy, 3'd2, 1, 8'd40, 8'd50, 3'd4, 0, 1);
    step(0, 0, 0, 8'd0, 8'd0, 3'd0, 1, 8'd41, 8'd51, 3'd6, 0, 1);
    idle();
    idle();
    chk(32'(exp_q.size()), 32'd0, "queue_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
